pattern_tx: RTL and testbench
=============================

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter RW, default 4, width of the repetition count input.
REQ-002 Parameter GW, default 2, width of the inter-repetition gap input.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 init  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-006 sel  input  2  pattern select: 00 = 0011, 01 = 1100, 10 = data, 11 = 0101.
REQ-007 data  input  4  user pattern, used when sel = 10.
REQ-008 reps  input  RW  number of pattern repetitions per frame.
REQ-009 gap  input  GW  idle cycles inserted between repetitions.
REQ-010 x  output  1  serial bit stream, MSB of pattern first; drives a 0011/1100 sequence detector.
REQ-011 valid  output  1  high when x carries a pattern bit.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 done  output  1  one-cycle pulse at frame end.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, GAP and FIN.
REQ-015 In IDLE with start = 1, sel, data, reps and gap SHALL be captured; later changes on these inputs SHALL have no effect until the next IDLE.
REQ-016 IDLE -> SHIFT on start with reps != 0; IDLE -> FIN on start with reps = 0 (no bits sent, done still pulses).
REQ-017 In SHIFT, x SHALL present pattern bits 3, 2, 1, 0 on four consecutive cycles with valid = 1; the first bit appears the cycle after start is sampled.
REQ-018 After bit 0: if repetitions remain and gap != 0 -> GAP; if repetitions remain and gap = 0 -> SHIFT with bit 3 next cycle (back-to-back); if none remain -> FIN.
REQ-019 GAP SHALL last exactly gap cycles with valid = 0, x = 0, then return to SHIFT.
REQ-020 FIN SHALL last one cycle with done = 1, valid = 0, x = 0, then go to IDLE.
REQ-021 busy SHALL be 1 in SHIFT, GAP and FIN, and 0 in IDLE.
REQ-022 start asserted while busy = 1 SHALL be ignored; no queuing.
REQ-023 start asserted in the FIN cycle SHALL be ignored; start in the IDLE cycle after FIN SHALL be accepted.
REQ-024 The repetition counter SHALL be RW bits wide; reps = all-ones SHALL send exactly 2^RW - 1 repetitions with no wrap.
REQ-025 Frame length in cycles from start sample to done SHALL be 4*reps + gap*(reps-1) + 1 for reps >= 1.
REQ-026 x and valid SHALL be registered outputs; valid = 0 implies x = 0.

Reset
REQ-027 init = 1 SHALL force state IDLE, x = 0, valid = 0, busy = 0, done = 0 and clear all counters and captured fields, independent of clk.
REQ-028 init asserted mid-frame SHALL abort the frame immediately with no done pulse; after init is released, the first rising edge SHALL evaluate IDLE.

Structure
REQ-029 The state enumeration and the pattern constants PAT_0011 = 0011, PAT_1100 = 1100 and PAT_ALT = 0101 SHALL reside in shared package pattern_tx_pkg.
REQ-030 The 4-bit load/shift register with bit counter SHALL be sub-module pattern_tx_shreg; the FSM and repetition/gap counters SHALL remain in pattern_tx.

Verification
REQ-031 sel = 00, reps = 1, gap = 0, start for one cycle -> x = 0,0,1,1 with valid = 1 on cycles 1-4, done on cycle 5; a sequence detector fed by x asserts z.
REQ-032 sel = 01, reps = 3, gap = 2 -> 1100, 00 idle, 1100, 00 idle, 1100; valid low in gaps; done on cycle 17.
REQ-033 sel = 10, data = 1010, reps = 2, gap = 0 -> 10101010 back-to-back, done on cycle 9; changing data mid-frame has no effect.
REQ-034 reps = 0, start -> busy and done high for one cycle on cycle 1, valid never asserted.
REQ-035 init asserted during bit 2 of repetition 2 -> all outputs 0 asynchronously, no done; a new start after release runs a full, correct frame.
REQ-036 start held high for an entire frame -> exactly one frame per accepted start, next frame begins the cycle after the IDLE cycle that follows FIN.

Source files
------------

// File: rtl/pattern_tx_pkg.sv
// Shared state encoding and fixed pattern constants for the pattern transmitter.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [3:0] PAT_0011 = 4'b0011;
  localparam logic [3:0] PAT_1100 = 4'b1100;
  localparam logic [3:0] PAT_ALT  = 4'b0101;

  localparam logic [1:0] SEL_0011 = 2'b00;
  localparam logic [1:0] SEL_1100 = 2'b01;
  localparam logic [1:0] SEL_DATA = 2'b10;
  localparam logic [1:0] SEL_ALT  = 2'b11;

  function automatic logic [3:0] pick_pattern(input logic [1:0] sel, input logic [3:0] data);
    logic [3:0] p;
    p = PAT_0011;
    case (sel)
      SEL_0011: p = PAT_0011;
      SEL_1100: p = PAT_1100;
      SEL_DATA: p = data;
      SEL_ALT:  p = PAT_ALT;
      default:  p = PAT_0011;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pattern_tx_shreg.sv
// 4-bit load/shift register: load emits bit 3 on the next cycle, each shift emits the next bit.
module pattern_tx_shreg
  import pattern_tx_pkg::*;
(
  input  logic       clk,
  input  logic       init,
  input  logic       load,
  input  logic       shift,
  input  logic [3:0] pat,
  output logic       x,
  output logic       valid,
  output logic       last
);

  logic [2:0] rest;
  logic [1:0] cnt;

  // cnt holds the bits still to follow the one currently on x
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      x     <= 1'b0;
      valid <= 1'b0;
      rest  <= 3'd0;
      cnt   <= 2'd0;
    end else if (load) begin
      x     <= pat[3];
      valid <= 1'b1;
      rest  <= pat[2:0];
      cnt   <= 2'd3;
    end else if (shift) begin
      x     <= rest[2];
      valid <= 1'b1;
      rest  <= {rest[1:0], 1'b0};
      cnt   <= cnt - 2'd1;
    end else begin
      x     <= 1'b0;
      valid <= 1'b0;
      cnt   <= 2'd0;
    end
  end

  assign last = valid && (cnt == 2'd0);

endmodule

// File: rtl/pattern_tx.sv
// Frame sequencer: repeats a 4-bit pattern reps times with gap idle cycles between repetitions.
// state | meaning
// IDLE  | waiting for start, captures frame fields
// SHIFT | pattern bits on x
// GAP   | idle cycles between repetitions
// FIN   | one-cycle done pulse
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int RW = 4,
  parameter int GW = 2
) (
  input  logic          clk,
  input  logic          init,
  input  logic          start,
  input  logic [1:0]    sel,
  input  logic [3:0]    data,
  input  logic [RW-1:0] reps,
  input  logic [GW-1:0] gap,
  output logic          x,
  output logic          valid,
  output logic          busy,
  output logic          done
);

  localparam logic [RW-1:0] REP_ONE = 1;
  localparam logic [GW-1:0] GAP_ONE = 1;

  state_t        state;
  logic [3:0]    pat_q;
  logic [RW-1:0] rep_cnt;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_cnt;
  logic          load;
  logic          shift;
  logic          last;
  logic [3:0]    pat_ld;

  always_comb begin
    load   = 1'b0;
    shift  = 1'b0;
    pat_ld = pat_q;
    case (state)
      IDLE: begin
        if (start && (reps != '0)) begin
          load   = 1'b1;
          pat_ld = pick_pattern(sel, data);
        end
      end
      SHIFT: begin
        if (!last) shift = 1'b1;
        else if ((rep_cnt != '0) && (gap_q == '0)) load = 1'b1;
      end
      GAP: begin
        if (gap_cnt == GAP_ONE) load = 1'b1;
      end
      default: ;
    endcase
  end

  // rep_cnt counts repetitions still to start after the current one
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state   <= IDLE;
      pat_q   <= 4'd0;
      rep_cnt <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_q <= pick_pattern(sel, data);
            gap_q <= gap;
            busy  <= 1'b1;
            if (reps == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state   <= SHIFT;
              rep_cnt <= reps - REP_ONE;
            end
          end
        end
        SHIFT: begin
          if (last) begin
            if (rep_cnt == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (gap_q == '0) begin
              rep_cnt <= rep_cnt - REP_ONE;
            end else begin
              state   <= GAP;
              gap_cnt <= gap_q;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_ONE) begin
            state   <= SHIFT;
            rep_cnt <= rep_cnt - REP_ONE;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pattern_tx_shreg u_shreg (
    .clk   (clk),
    .init  (init),
    .load  (load),
    .shift (shift),
    .pat   (pat_ld),
    .x     (x),
    .valid (valid),
    .last  (last)
  );

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized scoreboard bench for pattern_tx: a frame-level model queues the expected per-cycle outputs.
module tb_pattern_tx;

  localparam int RW = 4;
  localparam int GW = 2;

  typedef struct packed {
    logic x;
    logic valid;
    logic busy;
    logic done;
  } obs_t;

  logic          clk = 1'b0;
  logic          init = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    sel = 2'd0;
  logic [3:0]    data = 4'd0;
  logic [RW-1:0] reps = '0;
  logic [GW-1:0] gap = '0;
  logic          x, valid, busy, done;

  logic [1:0]    cur_sel = 2'd0;
  logic [3:0]    cur_data = 4'd0;
  logic [RW-1:0] cur_reps = '0;
  logic [GW-1:0] cur_gap = '0;

  obs_t plan[$];
  obs_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] det = 4'd0;
  bit   z_seen = 1'b0;

  always #5 clk = ~clk;

  pattern_tx #(.RW(RW), .GW(GW)) dut (
    .clk   (clk),
    .init  (init),
    .start (start),
    .sel   (sel),
    .data  (data),
    .reps  (reps),
    .gap   (gap),
    .x     (x),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  function automatic logic [3:0] ref_pattern(input logic [1:0] s, input logic [3:0] d);
    case (s)
      2'd0:    return 4'b0011;
      2'd1:    return 4'b1100;
      2'd2:    return d;
      default: return 4'b0101;
    endcase
  endfunction

  // Expected trace of one accepted frame, starting the cycle after start is sampled.
  task automatic build_frame(input logic [1:0] s, input logic [3:0] d, input int r, input int g);
    logic [3:0] p;
    obs_t o;
    p = ref_pattern(s, d);
    for (int i = 0; i < r; i++) begin
      for (int b = 3; b >= 0; b--) begin
        o = '{x: p[b], valid: 1'b1, busy: 1'b1, done: 1'b0};
        plan.push_back(o);
      end
      if (i < r - 1)
        for (int k = 0; k < g; k++) plan.push_back(obs_t'(4'b0010));
    end
    plan.push_back(obs_t'(4'b0011));
  endtask

  task automatic drive(input logic st);
    start = st;
    sel   = cur_sel;
    data  = cur_data;
    reps  = cur_reps;
    gap   = cur_gap;
  endtask

  task automatic step(input logic st);
    obs_t e;
    @(posedge clk);
    #1;
    drive(st);
    e = '0;
    if (plan.size() != 0) e = plan.pop_front();
    sb.push_back(e);
    if (!e.busy && st) build_frame(cur_sel, cur_data, int'(cur_reps), int'(cur_gap));
  endtask

  task automatic drain();
    while (plan.size() != 0) step(1'b0);
    step(1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic rand_fields();
    cur_sel  = 2'($urandom_range(0, 3));
    cur_data = 4'($urandom_range(0, 15));
    cur_reps = ($urandom_range(0, 5) == 0) ? RW'(15) : RW'($urandom_range(0, 4));
    cur_gap  = GW'($urandom_range(0, 3));
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = '{x: x, valid: valid, busy: busy, done: done};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL trace t=%0t x/valid/busy/done got %b required %b", $time, a, e);
      end
      if (valid) begin
        det = {det[2:0], x};
        if (det == 4'b0011) z_seen = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d miscompares so far", miscompares);
    $fatal(1);
  end

  initial begin
    int n;
    #1 init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {28'd0, x, valid, busy, done}, 32'd0);
    init = 1'b0;

    // sel 00, one repetition: 0011 then done; detector must fire
    cur_sel = 2'd0; cur_reps = RW'(1); cur_gap = GW'(0);
    step(1'b1);
    drain();
    chk("detector_z", {31'd0, z_seen}, 32'd1);

    // sel 01, three repetitions with two-cycle gaps
    cur_sel = 2'd1; cur_reps = RW'(3); cur_gap = GW'(2);
    step(1'b1);
    drain();

    // user data back-to-back, fields scrambled mid-frame
    cur_sel = 2'd2; cur_data = 4'b1010; cur_reps = RW'(2); cur_gap = GW'(0);
    step(1'b1);
    repeat (8) begin
      rand_fields();
      step(1'b0);
    end
    drain();

    // zero repetitions: done only
    cur_reps = RW'(0);
    step(1'b1);
    drain();

    // maximum repetitions with maximum gap
    cur_sel = 2'd3; cur_reps = RW'(15); cur_gap = GW'(3);
    step(1'b1);
    drain();

    // abort during bit 2 of repetition 2
    cur_sel = 2'd3; cur_reps = RW'(3); cur_gap = GW'(1);
    step(1'b1);
    repeat (6) step(1'b0);
    @(posedge clk);
    #1;
    init = 1'b1;
    start = 1'b0;
    #1;
    chk("abort_x", {31'd0, x}, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    plan.delete();
    sb.push_back(obs_t'(4'b0000));
    @(posedge clk);
    #1;
    init = 1'b0;
    cur_sel = 2'd0; cur_reps = RW'(2); cur_gap = GW'(1);
    drive(1'b1);
    sb.push_back(obs_t'(4'b0000));
    build_frame(cur_sel, cur_data, int'(cur_reps), int'(cur_gap));
    drain();

    // start held high across several frames
    cur_sel = 2'd0; cur_reps = RW'(1); cur_gap = GW'(0);
    repeat (14) step(1'b1);
    drain();

    // randomized frames with random start noise during busy
    repeat (40) begin
      rand_fields();
      repeat ($urandom_range(0, 2)) step(1'b0);
      step(1'b1);
      n = 0;
      while (plan.size() != 0 && n < 200) begin
        if ($urandom_range(0, 3) == 0) rand_fields();
        step(1'($urandom_range(0, 1)));
        n++;
      end
      drain();
    end

    @(negedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
